// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised, oversampled UART receiver. Samples every bit at its
//            midpoint, rejects false start bits, supports 5..9 data bits,
//            none/odd/even parity and 1 or 2 stop bits, and reports framing,
//            parity and overrun conditions. Received words sit in a holding
//            register that the consumer drains with a valid/ready handshake.
// Ports    : clock      - system clock, rising edge
//            reset_n    - synchronous reset, active low
//            enable     - 1 = receiver armed, 0 = ignore/abort frames
//            serial_in  - asynchronous RX line, idle high
//            data       - held received word
//            valid      - holding register contains an unread frame
//            ready      - consumer accepts the held frame when valid & ready
//            parity_err - parity mismatch on the held frame
//            frame_err  - a stop bit of the held frame was sampled low
//            overrun    - single-cycle pulse: frame dropped, holder was full
//            busy       - receiver is somewhere inside a frame (not idle)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    typedef enum logic [2:0] {
        c_ST_IDLE   = 3'd0,
        c_ST_START  = 3'd1,
        c_ST_DATA   = 3'd2,
        c_ST_PARITY = 3'd3,
        c_ST_STOP   = 3'd4,
        c_ST_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                 r_sync1_q;
    logic                 r_rx_q;
    state_t               r_state_q;
    logic [c_CNT_W-1:0]   r_cnt_q;
    logic [c_IDX_W-1:0]   r_idx_q;
    logic [DATA_BITS-1:0] r_shift_q;
    logic                 r_par_pend_q;
    logic                 r_frm_pend_q;
    logic [DATA_BITS-1:0] r_data_q;
    logic                 r_valid_q;
    logic                 r_perr_q;
    logic                 r_ferr_q;
    logic                 r_ovr_q;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t               w_state_d;
    logic [c_CNT_W-1:0]   w_cnt_d;
    logic [c_IDX_W-1:0]   w_idx_d;
    logic [DATA_BITS-1:0] w_shift_d;
    logic                 w_par_pend_d;
    logic                 w_frm_pend_d;
    logic [DATA_BITS-1:0] w_data_d;
    logic                 w_valid_d;
    logic                 w_perr_d;
    logic                 w_ferr_d;
    logic                 w_ovr_d;

    logic                 w_frame_done;
    logic                 w_frame_perr;
    logic                 w_frame_ferr;
    logic                 w_par_xor;
    logic                 w_par_bad;

    // XOR of all data bits together with the received parity bit: odd parity
    // wants this to be 1, even parity wants it to be 0.
    assign w_par_xor = (^r_shift_q) ^ r_rx_q;
    assign w_par_bad = (PARITY == 1) ? ~w_par_xor : w_par_xor;

    // ------------------------------------------------------------------
    // Receive FSM: next state, counters and shift register
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_idx_d      = r_idx_q;
        w_shift_d    = r_shift_q;
        w_par_pend_d = r_par_pend_q;
        w_frm_pend_d = r_frm_pend_q;
        w_frame_done = 1'b0;
        w_frame_perr = 1'b0;
        w_frame_ferr = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                if (enable && !r_rx_q) begin
                    w_state_d    = c_ST_START;
                    w_cnt_d      = '0;
                    w_idx_d      = '0;
                    w_par_pend_d = 1'b0;
                    w_frm_pend_d = 1'b0;
                end
            end

            // Half a bit period lands on the middle of the start bit; a high
            // line there means the falling edge was only a glitch.
            c_ST_START: begin
                if (r_cnt_q == c_HALF_LAST) begin
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = r_rx_q ? c_ST_IDLE : c_ST_DATA;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_ST_DATA: begin
                if (r_cnt_q == c_BIT_LAST) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_rx_q, r_shift_q[DATA_BITS-1:1]};
                    if (r_idx_q == c_DATA_LAST) begin
                        w_idx_d   = '0;
                        w_state_d = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
                    end else begin
                        w_idx_d = r_idx_q + c_IDX_ONE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_ST_PARITY: begin
                if (r_cnt_q == c_BIT_LAST) begin
                    w_cnt_d      = '0;
                    w_par_pend_d = w_par_bad;
                    w_state_d    = c_ST_STOP;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_ST_STOP: begin
                if (r_cnt_q == c_BIT_LAST) begin
                    w_cnt_d = '0;
                    if (!r_rx_q) begin
                        w_frm_pend_d = 1'b1;
                    end
                    if (r_idx_q == c_STOP_LAST) begin
                        w_idx_d      = '0;
                        w_frame_done = 1'b1;
                        w_frame_perr = r_par_pend_q;
                        w_frame_ferr = r_frm_pend_q | ~r_rx_q;
                        // A low final stop bit usually means a break: hold off
                        // start detection until the line returns high.
                        w_state_d    = r_rx_q ? c_ST_IDLE : c_ST_BREAK;
                    end else begin
                        w_idx_d = r_idx_q + c_IDX_ONE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_ST_BREAK: begin
                if (r_rx_q) begin
                    w_state_d = c_ST_IDLE;
                end
            end

            default: begin
                w_state_d = c_ST_IDLE;
                w_cnt_d   = '0;
                w_idx_d   = '0;
            end
        endcase

        // Disarming mid-frame abandons the frame without delivering it.
        if (!enable && (r_state_q != c_ST_IDLE)) begin
            w_state_d    = c_ST_IDLE;
            w_cnt_d      = '0;
            w_idx_d      = '0;
            w_frame_done = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_perr_d  = r_perr_q;
        w_ferr_d  = r_ferr_q;
        w_ovr_d   = 1'b0;

        // Transfer clears the status but leaves the last word on data.
        if (r_valid_q && ready) begin
            w_valid_d = 1'b0;
            w_perr_d  = 1'b0;
            w_ferr_d  = 1'b0;
        end

        // A completing frame may replace a word being transferred this same
        // cycle; it is only dropped when the holder stays occupied.
        if (w_frame_done) begin
            if (!r_valid_q || ready) begin
                w_data_d  = r_shift_q;
                w_valid_d = 1'b1;
                w_perr_d  = w_frame_perr;
                w_ferr_d  = w_frame_ferr;
            end else begin
                w_ovr_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1_q    <= 1'b1;
            r_rx_q       <= 1'b1;
            r_state_q    <= c_ST_IDLE;
            r_cnt_q      <= '0;
            r_idx_q      <= '0;
            r_shift_q    <= '0;
            r_par_pend_q <= 1'b0;
            r_frm_pend_q <= 1'b0;
            r_data_q     <= '0;
            r_valid_q    <= 1'b0;
            r_perr_q     <= 1'b0;
            r_ferr_q     <= 1'b0;
            r_ovr_q      <= 1'b0;
        end else begin
            r_sync1_q    <= serial_in;
            r_rx_q       <= r_sync1_q;
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_idx_q      <= w_idx_d;
            r_shift_q    <= w_shift_d;
            r_par_pend_q <= w_par_pend_d;
            r_frm_pend_q <= w_frm_pend_d;
            r_data_q     <= w_data_d;
            r_valid_q    <= w_valid_d;
            r_perr_q     <= w_perr_d;
            r_ferr_q     <= w_ferr_d;
            r_ovr_q      <= w_ovr_d;
        end
    end

    assign data       = r_data_q;
    assign valid      = r_valid_q;
    assign parity_err = r_perr_q;
    assign frame_err  = r_ferr_q;
    assign overrun    = r_ovr_q;
    assign busy       = (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Self-checking bench for uart_rx_param. One receiver uses even
//            parity, a second one no parity. Directed frames cover the main
//            corner cases, followed by random frames compared against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int D  = 8;
    // Valid rises after: 2 sync stages + 1 start-detect edge, half a bit to the
    // start-bit midpoint, then one bit period per data/parity/stop bit.
    localparam int LAT_P = 3 + H + C * (D + 1 + 1);
    localparam int LAT_N = 3 + H + C * (D + 0 + 1);

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b1;
    logic       ready   = 1'b0;
    logic       line    = 1'b1;
    logic       line_np = 1'b1;

    logic [7:0] data;
    logic       valid, parity_err, frame_err, overrun, busy;
    logic [7:0] data_np;
    logic       valid_np, parity_err_np, frame_err_np, overrun_np, busy_np;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(D), .PARITY(2), .STOP_BITS(1)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .serial_in(line),
        .data(data), .valid(valid), .ready(ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(D), .PARITY(0), .STOP_BITS(1)) dut_np (
        .clock(clock), .reset_n(reset_n), .enable(enable), .serial_in(line_np),
        .data(data_np), .valid(valid_np), .ready(ready), .parity_err(parity_err_np),
        .frame_err(frame_err_np), .overrun(overrun_np), .busy(busy_np)
    );

    initial forever #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: records every handshake transfer and event counts.
    logic [7:0] xd[$];
    logic       xp[$];
    logic       xf[$];
    logic [7:0] nd[$];
    logic       np_pe[$];
    int         vhi = 0, ovr = 0, rise = -1, nrise = -1;
    logic       pv = 1'b0, npv = 1'b0;

    always @(negedge clock) begin
        if (valid && !pv) rise <= cyc;
        pv <= valid;
        if (valid) vhi <= vhi + 1;
        if (overrun) ovr <= ovr + 1;
        if (valid && ready) begin
            xd.push_back(data);
            xp.push_back(parity_err);
            xf.push_back(frame_err);
        end
        if (valid_np && !npv) nrise <= cyc;
        npv <= valid_np;
        if (valid_np && ready) begin
            nd.push_back(data_np);
            np_pe.push_back(parity_err_np);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] w);
        return ^w;
    endfunction

    task automatic drive_bit(input bit np, input logic b);
        if (np) line_np = b; else line = b;
        repeat (C) begin @(posedge clock); #1; end
    endtask

    // Sends start, 8 data bits LSB first, parity (main receiver only), stop.
    // The line is left at the stop-bit level.
    task automatic send(input bit np, input logic [7:0] w, input logic pb,
                        input logic sb, output int t0);
        t0 = cyc;
        drive_bit(np, 1'b0);
        for (int i = 0; i < D; i++) drive_bit(np, w[i]);
        if (!np) drive_bit(np, pb);
        drive_bit(np, sb);
    endtask

    task automatic chk_xfer(input string tag, input int idx, input logic [7:0] ed,
                            input logic ep, input logic ef);
        check({tag, "_count"}, xd.size(), idx + 1);
        if (xd.size() > idx) begin
            check({tag, "_data"}, xd[idx], ed);
            check({tag, "_perr"}, xp[idx], ep);
            check({tag, "_ferr"}, xf[idx], ef);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        int t0, q0, v0, o0, k, gap;
        logic [7:0] w;
        logic pb, sb;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_np_out", {data_np, valid_np, parity_err_np, frame_err_np, overrun_np, busy_np}, 0);
        reset_n = 1'b1;
        ready   = 1'b1;
        idle(5);

        // ---------------- 1: clean 0xA5 ----------------
        q0 = xd.size(); v0 = vhi; o0 = ovr;
        send(0, 8'hA5, even_par(8'hA5), 1'b1, t0);
        line = 1'b1;
        idle(C);
        chk_xfer("t1", q0, 8'hA5, 1'b0, 1'b0);
        check("t1_latency", rise, t0 + LAT_P);
        check("t1_valid_cycles", vhi - v0, 1);
        check("t1_no_ovr", ovr - o0, 0);

        // ---------------- 2: bad parity, then no-parity receiver ----------------
        q0 = xd.size();
        send(0, 8'h3C, ~even_par(8'h3C), 1'b1, t0);
        line = 1'b1;
        idle(C);
        chk_xfer("t2", q0, 8'h3C, 1'b1, 1'b0);
        q0 = nd.size();
        send(1, 8'h3C, 1'b0, 1'b1, t0);
        line_np = 1'b1;
        idle(C);
        check("t2np_count", nd.size(), q0 + 1);
        if (nd.size() > q0) begin
            check("t2np_data", nd[q0], 8'h3C);
            check("t2np_perr", np_pe[q0], 0);
        end
        check("t2np_latency", nrise, t0 + LAT_N);

        // ---------------- 3: framing error + break, then clean frame ----------------
        q0 = xd.size();
        send(0, 8'h55, even_par(8'h55), 1'b0, t0);
        idle(40);
        check("t3_busy_in_break", busy, 1);
        check("t3_one_frame", xd.size(), q0 + 1);
        if (xd.size() > q0) begin
            check("t3_data", xd[q0], 8'h55);
            check("t3_ferr", xf[q0], 1);
        end
        line = 1'b1;
        idle(4);
        check("t3_break_exit", busy, 0);
        send(0, 8'h0F, even_par(8'h0F), 1'b1, t0);
        line = 1'b1;
        idle(C);
        chk_xfer("t3b", q0 + 1, 8'h0F, 1'b0, 1'b0);
        check("t3b_latency", rise, t0 + LAT_P);

        // ---------------- 4: short glitch ----------------
        v0 = vhi; q0 = xd.size();
        line = 1'b0;
        idle(4);
        check("t4_busy_seen", busy, 1);
        line = 1'b1;
        k = 0;
        while (busy && k < H + 3) begin
            idle(1);
            k++;
        end
        check("t4_busy_bound", busy, 0);
        idle(2 * C);
        check("t4_no_valid", vhi - v0, 0);
        check("t4_no_xfer", xd.size(), q0);

        // ---------------- 5: overrun ----------------
        ready = 1'b0;
        q0 = xd.size(); o0 = ovr;
        send(0, 8'h11, even_par(8'h11), 1'b1, t0);
        line = 1'b1;
        idle(4);
        check("t5_valid_first", valid, 1);
        check("t5_data_first", data, 8'h11);
        send(0, 8'h22, even_par(8'h22), 1'b1, t0);
        line = 1'b1;
        idle(4);
        check("t5_data_kept", data, 8'h11);
        check("t5_valid_kept", valid, 1);
        check("t5_ovr_pulses", ovr - o0, 1);
        ready = 1'b1;
        idle(1);
        check("t5_valid_cleared", valid, 0);
        check("t5_data_after_xfer", data, 8'h11);
        chk_xfer("t5", q0, 8'h11, 1'b0, 1'b0);

        // ---------------- 6: reset mid-frame ----------------
        w = 8'h99;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, w[i]);
        line = w[3];
        idle(H);
        check("t6_busy_before", busy, 1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check("t6_rst_out", {data, valid, parity_err, frame_err, overrun, busy}, 0);
        line = 1'b1;
        idle(2 * C);
        q0 = xd.size();
        send(0, 8'h99, even_par(8'h99), 1'b1, t0);
        line = 1'b1;
        idle(C);
        chk_xfer("t6", q0, 8'h99, 1'b0, 1'b0);

        // ---------------- random frames vs reference model ----------------
        for (int n = 0; n < 8; n++) begin
            w   = 8'($urandom);
            pb  = even_par(w) ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 4) != 0);
            q0  = xd.size();
            send(0, w, pb, sb, t0);
            line = 1'b1;
            gap = $urandom_range(2, 20);
            idle(gap);
            chk_xfer("rnd", q0, w, pb != even_par(w), !sb);
            check("rnd_latency", rise, t0 + LAT_P);
        end
        idle(C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
